// File: rtl/core_sequencer_if.sv
// core_sequencer_if: instruction and data memory request/acknowledge bus.
// The sequencer is the master; the memories sit on the slave side.
interface core_sequencer_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ack;
    modport master (
        output imem_req, imem_addr, dmem_req, dmem_we,
        input  imem_ack, imem_rdata, dmem_ack
    );
    modport slave (
        input  imem_req, imem_addr, dmem_req, dmem_we,
        output imem_ack, imem_rdata, dmem_ack
    );
endinterface

// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle RV32I control sequencer (fetch, exec, mem, writeback).
// Define SEQ_PERF_CNT_EN to add the cycle_cnt/instret_cnt performance counters.
module core_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    core_sequencer_if.master bus,
    output logic [31:0] instr,
    input  logic        PL,
    input  logic        JB,
    input  logic        BC,
    input  logic [31:0] PCOffset,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic        rf_we,
    input  logic        Z,
    input  logic        N,
    output logic        dp_we,
    output logic [31:0] pc,
    output logic        busy
`ifdef SEQ_PERF_CNT_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret_cnt
`endif
);
    typedef enum logic [2:0] {IDLE, FETCH, EXEC, MEM, WB} state_t;
    state_t      state, state_nxt;
    logic        flag_z, flag_n, taken;
    logic [31:0] target;
    assign target        = pc + PCOffset;
    assign taken         = PL & (JB | (BC ? flag_n : flag_z));
    assign bus.imem_addr = pc;
    assign busy          = state != IDLE;
    // a store with rf_we set must never write the register file
    assign dp_we         = (state == WB) & rf_we & ~mem_wr;
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = run ? FETCH : IDLE;
            FETCH:   state_nxt = bus.imem_ack ? EXEC : FETCH;
            EXEC:    state_nxt = (mem_rd | mem_wr) ? MEM : WB;
            MEM:     state_nxt = bus.dmem_ack ? WB : MEM;
            WB:      state_nxt = run ? FETCH : IDLE;
            default: state_nxt = IDLE;
        endcase
    end
    // requests are registered from the next state so they align with the state they belong to
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            pc           <= RESET_PC;
            instr        <= '0;
            flag_z       <= 1'b0;
            flag_n       <= 1'b0;
            bus.imem_req <= 1'b0;
            bus.dmem_req <= 1'b0;
            bus.dmem_we  <= 1'b0;
        end else begin
            state        <= state_nxt;
            bus.imem_req <= state_nxt == FETCH;
            bus.dmem_req <= state_nxt == MEM;
            bus.dmem_we  <= (state_nxt == MEM) & mem_wr;
            if (state == FETCH && bus.imem_ack) instr <= bus.imem_rdata;
            if (state == EXEC) begin
                flag_z <= Z;
                flag_n <= N;
            end
            if (state == WB) pc <= taken ? {target[31:2], 2'b00} : pc + PC_STEP;
        end
    end
`ifdef SEQ_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            cycle_cnt   <= cycle_cnt + {31'd0, busy};
            instret_cnt <= instret_cnt + {31'd0, state == WB};
        end
    end
`endif
endmodule
